// File: rtl/adder_accumulator_pkg.sv
// Shared definitions for the adder_accumulator block.
//   state_t          : accumulator FSM states
//   DEF_NUM_BITS     : default operand / sum width
//   DEF_NUM_OPERANDS : default number of operands summed per result
package adder_accumulator_pkg;

    localparam int DEF_NUM_BITS     = 4;
    localparam int DEF_NUM_OPERANDS = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/adder_nbit.sv
// Unsigned ripple-style N-bit adder with carry in and carry out.
//   a, b      : NUM_BITS-wide operands
//   carry_in  : carry into bit 0
//   sum       : (a + b + carry_in) modulo 2^NUM_BITS
//   overflow  : carry out of the most significant bit
module adder_nbit
    import adder_accumulator_pkg::*;
#(
    parameter int NUM_BITS = DEF_NUM_BITS
) (
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    input  logic                carry_in,
    output logic [NUM_BITS-1:0] sum,
    output logic                overflow
);

    assign {overflow, sum} = {1'b0, a} + {1'b0, b} + {{NUM_BITS{1'b0}}, carry_in};

endmodule

// File: rtl/adder_accumulator.sv
// Sums NUM_OPERANDS unsigned operands into one result with a sticky carry flag.
//   clk, rst             : clock, synchronous active-high reset
//   clear                : synchronous abort of the current accumulation
//   in_valid/in_ready    : operand handshake, in_data is the operand
//   out_valid/out_ready  : result handshake, out_sum/out_overflow are the result
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for the first operand of a new result
// ST_ACCUM | first operand taken, adding further operands
// ST_DONE  | result presented, held until out_ready
module adder_accumulator
    import adder_accumulator_pkg::*;
#(
    parameter int NUM_BITS     = DEF_NUM_BITS,
    parameter int NUM_OPERANDS = DEF_NUM_OPERANDS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                in_valid,
    input  logic [NUM_BITS-1:0] in_data,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NUM_BITS-1:0] out_sum,
    output logic                out_overflow
);

    localparam int CNT_W = $clog2(NUM_OPERANDS + 1);
    localparam logic [CNT_W-1:0] COUNT_LAST = CNT_W'(NUM_OPERANDS);

    state_t              state;
    state_t              state_next;
    logic [NUM_BITS-1:0] acc;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    count_inc;
    logic                overflow;
    logic                accept;
    logic [NUM_BITS-1:0] add_sum;
    logic                add_carry;

    adder_nbit #(
        .NUM_BITS (NUM_BITS)
    ) u_adder (
        .a        (acc),
        .b        (in_data),
        .carry_in (1'b0),
        .sum      (add_sum),
        .overflow (add_carry)
    );

    assign accept    = in_valid && in_ready;
    assign count_inc = count + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = (NUM_OPERANDS == 1) ? ST_DONE : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (accept && (count_inc == COUNT_LAST)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // clear overrides every handshake in every state
        if (clear) begin
            state_next = ST_IDLE;
        end
    end

    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        if (state == ST_DONE) begin
            in_ready  = 1'b0;
            out_valid = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc      <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        acc      <= in_data;
                        count    <= CNT_W'(1);
                        overflow <= 1'b0;
                    end
                end
                ST_ACCUM: begin
                    if (accept) begin
                        acc      <= add_sum;
                        overflow <= overflow | add_carry;
                        count    <= count_inc;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        acc      <= '0;
                        count    <= '0;
                        overflow <= 1'b0;
                    end
                end
                default: begin
                    acc      <= '0;
                    count    <= '0;
                    overflow <= 1'b0;
                end
            endcase
        end
    end

    // result registers drive the outputs directly
    assign out_sum      = acc;
    assign out_overflow = overflow;

endmodule

// File: tb/tb_adder_accumulator.sv
module tb_adder_accumulator;

    logic       clk;
    logic       rst;
    logic       clear;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_sum;
    logic       out_overflow;

    int checks = 0;
    int errors = 0;

    adder_accumulator #(
        .NUM_BITS     (4),
        .NUM_OPERANDS (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_overflow (out_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] v);
        in_valid = 1'b1;
        in_data  = v;
        step();
    endtask

    // four back-to-back operands, result checked in DONE, optionally consumed
    task automatic stream(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d,
                          input logic [3:0] exp_sum, input logic exp_ovf,
                          input logic consume, input string tag);
        out_ready = 1'b0;
        push(a);
        push(b);
        push(c);
        check({tag, " valid_before_last"}, 8'(out_valid), 8'd0);
        push(d);
        in_valid = 1'b0;
        check({tag, " out_valid"}, 8'(out_valid), 8'd1);
        check({tag, " in_ready"},  8'(in_ready),  8'd0);
        check({tag, " sum"},       8'(out_sum),   8'(exp_sum));
        check({tag, " ovf"},       8'(out_overflow), 8'(exp_ovf));
        if (consume) begin
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            check({tag, " idle_valid"}, 8'(out_valid), 8'd0);
            check({tag, " idle_ready"}, 8'(in_ready),  8'd1);
        end
    endtask

    initial begin
        logic [3:0] ops [4];
        int         run;
        int         t;
        logic       m_ovf;

        rst       = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'd0;
        out_ready = 1'b0;
        step();
        step();
        check("rst in_ready",  8'(in_ready),  8'd1);
        check("rst out_valid", 8'(out_valid), 8'd0);
        check("rst out_sum",   8'(out_sum),   8'd0);
        check("rst out_ovf",   8'(out_overflow), 8'd0);
        rst = 1'b0;
        step();

        // basic sum and wrap/flag behaviour
        stream(4'd1,  4'd2,  4'd3,  4'd4,  4'd10, 1'b0, 1'b1, "s1234");
        check("s1234 cleared_sum", 8'(out_sum), 8'd0);
        stream(4'd15, 4'd1,  4'd0,  4'd0,  4'd0,  1'b1, 1'b1, "s15_1");
        stream(4'd15, 4'd15, 4'd15, 4'd15, 4'd12, 1'b1, 1'b1, "s15x4");
        stream(4'd1,  4'd1,  4'd1,  4'd1,  4'd4,  1'b0, 1'b1, "s1x4");

        // backpressure in DONE with a competing operand
        stream(4'd1, 4'd2, 4'd3, 4'd4, 4'd10, 1'b0, 1'b0, "bp");
        in_valid = 1'b1;
        in_data  = 4'd7;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp in_ready",  8'(in_ready),  8'd0);
            check("bp out_valid", 8'(out_valid), 8'd1);
            check("bp out_sum",   8'(out_sum),   8'd10);
            check("bp out_ovf",   8'(out_overflow), 8'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp release", 8'(out_valid), 8'd0);
        stream(4'd1, 4'd1, 4'd1, 4'd1, 4'd4, 1'b0, 1'b1, "bp_after");

        // gapped input
        push(4'd2);
        in_valid = 1'b0;
        step();
        check("gap in_ready", 8'(in_ready), 8'd1);
        step();
        push(4'd3);
        in_valid = 1'b0;
        step();
        check("gap out_valid", 8'(out_valid), 8'd0);
        push(4'd4);
        push(4'd5);
        in_valid = 1'b0;
        check("gap valid", 8'(out_valid), 8'd1);
        check("gap sum",   8'(out_sum),   8'd14);
        check("gap ovf",   8'(out_overflow), 8'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // clear mid-accumulation, same-cycle operand discarded
        push(4'd5);
        push(4'd6);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'd9;
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clr in_ready",  8'(in_ready),  8'd1);
        check("clr out_valid", 8'(out_valid), 8'd0);
        check("clr out_sum",   8'(out_sum),   8'd0);
        stream(4'd1, 4'd1, 4'd1, 4'd1, 4'd4, 1'b0, 1'b1, "clr_after");

        // clear in DONE wins over out_ready and drops the result
        stream(4'd8, 4'd8, 4'd1, 4'd0, 4'd1, 1'b1, 1'b0, "clr_done");
        clear     = 1'b1;
        out_ready = 1'b1;
        step();
        clear     = 1'b0;
        out_ready = 1'b0;
        check("clr_done valid", 8'(out_valid), 8'd0);
        check("clr_done ovf",   8'(out_overflow), 8'd0);

        // reset in ACCUM after three operands
        push(4'd15);
        push(4'd15);
        push(4'd15);
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_acc in_ready",  8'(in_ready),  8'd1);
        check("rst_acc out_valid", 8'(out_valid), 8'd0);
        check("rst_acc out_sum",   8'(out_sum),   8'd0);
        check("rst_acc out_ovf",   8'(out_overflow), 8'd0);
        push(4'd1);
        in_valid = 1'b0;
        check("rst_acc no_stale", 8'(out_valid), 8'd0);
        push(4'd2);
        push(4'd3);
        push(4'd4);
        in_valid = 1'b0;
        check("rst_acc fresh_valid", 8'(out_valid), 8'd1);
        check("rst_acc fresh_sum",   8'(out_sum),   8'd10);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // reset in DONE while held
        stream(4'd9, 4'd9, 4'd0, 4'd0, 4'd2, 1'b1, 1'b0, "rst_done");
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_done valid", 8'(out_valid), 8'd0);
        check("rst_done sum",   8'(out_sum),   8'd0);
        check("rst_done ovf",   8'(out_overflow), 8'd0);
        check("rst_done ready", 8'(in_ready),  8'd1);

        // random streams against a stepwise modulo-16 / carry model
        for (run = 0; run < 200; run++) begin
            for (int k = 0; k < 4; k++) ops[k] = 4'($urandom_range(0, 15));
            t     = int'(ops[0]);
            m_ovf = 1'b0;
            for (int k = 1; k < 4; k++) begin
                t = t + int'(ops[k]);
                if (t > 15) begin
                    m_ovf = 1'b1;
                    t     = t - 16;
                end
            end
            stream(ops[0], ops[1], ops[2], ops[3], 4'(t), m_ovf, 1'b1, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
